// File: rtl/mcu_bus_transmitter.sv
// mcu_bus_transmitter: queued command/data byte serialiser for the MCU bus.
// Build with MCU_BUS_PIXEL_PACK_EN to add the 12-bit pixel packing path.
module mcu_bus_transmitter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HALF_PERIOD = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   system_clock,
  input  logic                   reset_n,
  input  logic [7:0]             in_data,
  input  logic                   in_command,
  input  logic                   in_valid,
  output logic                   in_ready,
`ifdef MCU_BUS_PIXEL_PACK_EN
  input  logic [11:0]            pixel_data,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  input  logic                   pixel_flush,
`endif
  output logic                   mcu_bus_clock,
  output logic [7:0]             mcu_bus_out,
  output logic                   mcu_bus_oe,
  output logic                   mcu_bus_command_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] bytes_sent
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH
  } state_t;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic          push, pop;
  logic [8:0]    push_word;
  logic [8:0]    head;
  logic          pack_idle_n;

  assign head    = mem[rptr];
  assign count_n = count + CW'(push) - CW'(pop);

`ifdef MCU_BUS_PIXEL_PACK_EN
  logic        held;
  logic [11:0] p0;
  logic [23:0] pbuf;
  logic [1:0]  pend, pend_n;
  logic        pk_push, pix_take, flush_take, pair_done;

  assign pk_push    = (pend != 2'd0) && (count != DEPTH_C);
  assign pix_take   = pixel_valid && pixel_ready;
  assign flush_take = pixel_flush && held && pixel_ready && !pixel_valid;
  assign pair_done  = pix_take && held;
  assign push       = pk_push || (in_valid && in_ready);
  assign push_word  = pk_push ? {1'b0, pbuf[23:16]}
                              : {in_command, in_data};

  always_comb begin
    pend_n = pend;
    if (pk_push)
      pend_n = pend - 2'd1;
    else if (pair_done || flush_take)
      pend_n = 2'd3;
  end

  assign pack_idle_n = (pend_n == 2'd0);

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      held        <= 1'b0;
      p0          <= '0;
      pbuf        <= '0;
      pend        <= 2'd0;
      pixel_ready <= 1'b1;
    end else begin
      pend        <= pend_n;
      pixel_ready <= pack_idle_n;
      if (pk_push) begin
        pbuf <= {pbuf[15:0], 8'h00};
      end else if (pair_done) begin
        pbuf <= {p0, pixel_data};
        held <= 1'b0;
      end else if (flush_take) begin
        pbuf <= {p0, 12'h000};
        held <= 1'b0;
      end else if (pix_take) begin
        p0   <= pixel_data;
        held <= 1'b1;
      end
    end
  end
`else
  assign push        = in_valid && in_ready;
  assign push_word   = {in_command, in_data};
  assign pack_idle_n = 1'b1;
`endif

  always_ff @(posedge system_clock) begin
    if (push)
      mem[wptr] <= push_word;
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count_n;
    end
  end

  state_t           state, state_n;
  logic [PW-1:0]    phase, phase_n;
  logic             tail, tail_n;
  logic             clk_n, oe_n, cd_n;
  logic [7:0]       out_n;
  logic [COUNT_WIDTH-1:0] sent_n;

  always_comb begin
    state_n = state;
    phase_n = phase;
    tail_n  = tail;
    clk_n   = mcu_bus_clock;
    oe_n    = mcu_bus_oe;
    out_n   = mcu_bus_out;
    cd_n    = mcu_bus_command_data;
    sent_n  = bytes_sent;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        clk_n = 1'b0;
        oe_n  = 1'b0;
        if (count != '0) begin
          pop     = 1'b1;
          {cd_n, out_n} = head;
          oe_n    = 1'b1;
          phase_n = '0;
          tail_n  = 1'b0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (tail) begin
            // trailing low phase done: release the bus
            oe_n    = 1'b0;
            tail_n  = 1'b0;
            state_n = IDLE;
          end else begin
            clk_n   = 1'b1;
            state_n = HIGH;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      HIGH: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          clk_n   = 1'b0;
          sent_n  = bytes_sent + COUNT_WIDTH'(1);
          state_n = SETUP;
          if (count != '0) begin
            pop = 1'b1;
            {cd_n, out_n} = head;
          end else begin
            tail_n = 1'b1;
          end
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      phase                <= '0;
      tail                 <= 1'b0;
      mcu_bus_clock        <= 1'b0;
      mcu_bus_oe           <= 1'b0;
      mcu_bus_out          <= 8'h00;
      mcu_bus_command_data <= 1'b0;
      bytes_sent           <= '0;
      in_ready             <= 1'b1;
      busy                 <= 1'b0;
    end else begin
      state                <= state_n;
      phase                <= phase_n;
      tail                 <= tail_n;
      mcu_bus_clock        <= clk_n;
      mcu_bus_oe           <= oe_n;
      mcu_bus_out          <= out_n;
      mcu_bus_command_data <= cd_n;
      bytes_sent           <= sent_n;
      in_ready             <= (count_n != DEPTH_C) && pack_idle_n;
      busy                 <= (count_n != '0) || (state_n != IDLE);
    end
  end

endmodule
